// File: rtl/gpr_file_mp.sv
// ============================================================================
// Module   : gpr_file_mp
// Brief    : Multi-port GPR file with write bypass and a pending-write
//            scoreboard; optional write trace when GPR_TRACE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rrdy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [31:0]              pc0,
  input  logic [31:0]              pc1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     sb_flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int c_DEPTH = 1 << ADDR_W;
  localparam int c_CW    = ADDR_W + 1;

  logic [DATA_W-1:0]  w_mem [c_DEPTH];
  logic [c_DEPTH-1:0] w_pend;
  logic [c_DEPTH-1:0] w_pend_nxt;
  logic [c_CW-1:0]    w_cnt_nxt;
  logic [c_CW-1:0]    r_cnt;

  // Register 0 has no storage and can never be pending.
  assign w_mem[0]      = '0;
  assign w_pend[0]     = 1'b0;
  assign w_pend_nxt[0] = 1'b0;

  for (genvar i = 1; i < c_DEPTH; i++) begin : g_reg
    logic              w_hit0;
    logic              w_hit1;
    logic              w_claim;
    logic [DATA_W-1:0] r_data;
    logic              r_pend;

    assign w_hit0  = we0    && (wa0     == ADDR_W'(i));
    assign w_hit1  = we1    && (wa1     == ADDR_W'(i));
    assign w_claim = sb_set && (sb_addr == ADDR_W'(i));

    // Port 1 carries the younger result, so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_data <= '0;
      end else if (w_hit1) begin
        r_data <= wd1;
      end else if (w_hit0) begin
        r_data <= wd0;
      end
    end

    assign w_pend_nxt[i] = sb_flush            ? 1'b0 :
                           w_claim             ? 1'b1 :
                           (w_hit0 || w_hit1)  ? 1'b0 : r_pend;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= w_pend_nxt[i];
      end
    end

    assign w_mem[i]  = r_data;
    assign w_pend[i] = r_pend;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < c_DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + c_CW'(w_pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign pend_cnt = r_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_byp0;
    logic              w_byp1;

    assign w_ra   = ra[k*ADDR_W +: ADDR_W];
    assign w_zero = (w_ra == '0);
    assign w_byp0 = we0 && (wa0 == w_ra);
    assign w_byp1 = we1 && (wa1 == w_ra);

    assign rd[k*DATA_W +: DATA_W] = w_zero ? '0  :
                                    w_byp1 ? wd1 :
                                    w_byp0 ? wd0 : w_mem[w_ra];

    // A write landing this cycle satisfies the operand even if still pending.
    assign rrdy[k] = w_zero || !w_pend[w_ra] || w_byp0 || w_byp1;
  end

`ifdef GPR_TRACE_EN
  always @(posedge clk) begin
    if (reset_n) begin
      if (we0 && (wa0 != '0) && !(we1 && (wa1 == wa0))) begin
        $display("%d@%h: $%d <= %h", $time, pc0, wa0, wd0);
      end
      if (we1 && (wa1 != '0)) begin
        $display("%d@%h: $%d <= %h", $time, pc1, wa1, wd1);
      end
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{pc0, pc1};
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
// ============================================================================
// Module   : tb_gpr_file_mp
// Brief    : Directed self-checking bench for gpr_file_mp (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpr_file_mp;

  logic        clk;
  logic        reset_n;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rrdy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [31:0] pc0, pc1;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        sb_flush;
  logic [5:0]  pend_cnt;

  int n_vec;
  int n_err;

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra       (ra),
    .rd       (rd),
    .rrdy     (rrdy),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .pc0      (pc0),
    .pc1      (pc1),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_flush (sb_flush),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_1234;
    sb_set = 1'b1; sb_addr = 5'd1;
    @(negedge clk);
    idle(); ra = {5'd1, 5'd3};
    #1;
    n_vec++; if (rd[31:0] !== 32'h0000_1234) begin n_err++; $display("FAIL pre_reset_rd: got %h want %h", rd[31:0], 32'h0000_1234); end
    n_vec++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 1", pend_cnt); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_DEAD;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL reset_async_cnt: got %0d want 0", pend_cnt); end
    @(negedge clk);
    idle(); reset_n = 1'b1;
    #1;
    n_vec++; if (rd[31:0] !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h want 0", rd[31:0]); end
    n_vec++; if (rrdy !== 2'b11) begin n_err++; $display("FAIL reset_rrdy: got %b want 11", rrdy); end
    n_vec++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", pend_cnt); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
    ra = {5'd5, 5'd5};
    #1;
    n_vec++; if (rd[31:0] !== 32'h22) begin n_err++; $display("FAIL byp_prio: got %h want %h", rd[31:0], 32'h22); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (rd[63:32] !== 32'h22) begin n_err++; $display("FAIL byp_prio_stored: got %h want %h", rd[63:32], 32'h22); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hAAAA_0010;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hBBBB_0011;
    ra = {5'd11, 5'd10};
    #1;
    n_vec++; if (rd !== {32'hBBBB_0011, 32'hAAAA_0010}) begin n_err++; $display("FAIL byp_dual: got %h want %h", rd, {32'hBBBB_0011, 32'hAAAA_0010}); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (rd !== {32'hBBBB_0011, 32'hAAAA_0010}) begin n_err++; $display("FAIL dual_stored: got %h want %h", rd, {32'hBBBB_0011, 32'hAAAA_0010}); end
  endtask

  task automatic test_zero();
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    sb_set = 1'b1; sb_addr = 5'd0;
    ra = {5'd5, 5'd0};
    #1;
    n_vec++; if (rd[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_byp: got %h want 0", rd[31:0]); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (rd[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_stored: got %h want 0", rd[31:0]); end
    n_vec++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL zero_sb_noop: got %0d want 0", pend_cnt); end
    n_vec++; if (rrdy[0] !== 1'b1) begin n_err++; $display("FAIL zero_rrdy: got %b want 1", rrdy[0]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd7;
    ra = {5'd5, 5'd7};
    #1;
    n_vec++; if (rrdy[0] !== 1'b1) begin n_err++; $display("FAIL sb_before_edge: got %b want 1", rrdy[0]); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (rrdy !== 2'b10) begin n_err++; $display("FAIL sb_pending_rrdy: got %b want 10", rrdy); end
    n_vec++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL sb_pending_cnt: got %0d want 1", pend_cnt); end
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77;
    #1;
    n_vec++; if (rrdy[0] !== 1'b1) begin n_err++; $display("FAIL sb_clear_rrdy: got %b want 1", rrdy[0]); end
    n_vec++; if (rd[31:0] !== 32'h77) begin n_err++; $display("FAIL sb_clear_rd: got %h want %h", rd[31:0], 32'h77); end
    n_vec++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL sb_clear_cnt_pre: got %0d want 1", pend_cnt); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL sb_clear_cnt: got %0d want 0", pend_cnt); end
    n_vec++; if (rrdy[0] !== 1'b1) begin n_err++; $display("FAIL sb_cleared_rrdy: got %b want 1", rrdy[0]); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd9;
    @(negedge clk);
    sb_set = 1'b1; sb_addr = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    ra = {5'd5, 5'd9};
    #1;
    n_vec++; if (rrdy[0] !== 1'b1) begin n_err++; $display("FAIL coll_rrdy_wr: got %b want 1", rrdy[0]); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL coll_cnt: got %0d want 1", pend_cnt); end
    n_vec++; if (rrdy[0] !== 1'b0) begin n_err++; $display("FAIL coll_still_pend: got %b want 0", rrdy[0]); end
    n_vec++; if (rd[31:0] !== 32'h99) begin n_err++; $display("FAIL coll_data: got %h want %h", rd[31:0], 32'h99); end
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9A;
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL coll_release: got %0d want 0", pend_cnt); end
    n_vec++; if (rd[31:0] !== 32'h9A) begin n_err++; $display("FAIL port0_commit: got %h want %h", rd[31:0], 32'h9A); end
  endtask

  task automatic test_flush();
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      sb_set = 1'b1; sb_addr = 5'(i);
    end
    @(negedge clk);
    idle();
    ra = {5'd5, 5'd2};
    #1;
    n_vec++; if (pend_cnt !== 6'd4) begin n_err++; $display("FAIL flush_pre_cnt: got %0d want 4", pend_cnt); end
    n_vec++; if (rrdy !== 2'b00) begin n_err++; $display("FAIL flush_pre_rrdy: got %b want 00", rrdy); end
    @(negedge clk);
    sb_flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd2;
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (pend_cnt !== 6'd0) begin n_err++; $display("FAIL flush_cnt: got %0d want 0", pend_cnt); end
    n_vec++; if (rrdy !== 2'b11) begin n_err++; $display("FAIL flush_rrdy: got %b want 11", rrdy); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h0000_0001;
    we0 = 1'b1; wa0 = 5'd13; wd0 = 32'h0000_0101;
    ra = {5'd13, 5'd12};
    @(negedge clk);
    wd1 = 32'h0000_0002; wd0 = 32'h0000_0102;
    sb_set = 1'b1; sb_addr = 5'd30;
    #1;
    n_vec++; if (rd !== {32'h0000_0102, 32'h0000_0002}) begin n_err++; $display("FAIL b2b_byp: got %h want %h", rd, {32'h0000_0102, 32'h0000_0002}); end
    @(negedge clk);
    idle();
    sb_set = 1'b1; sb_addr = 5'd31;
    #1;
    n_vec++; if (rd !== {32'h0000_0102, 32'h0000_0002}) begin n_err++; $display("FAIL b2b_stored: got %h want %h", rd, {32'h0000_0102, 32'h0000_0002}); end
    n_vec++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL b2b_cnt1: got %0d want 1", pend_cnt); end
    @(negedge clk);
    idle();
    ra = {5'd31, 5'd30};
    #1;
    n_vec++; if (pend_cnt !== 6'd2) begin n_err++; $display("FAIL b2b_cnt2: got %0d want 2", pend_cnt); end
    n_vec++; if (rrdy !== 2'b00) begin n_err++; $display("FAIL b2b_rrdy: got %b want 00", rrdy); end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    ra      = '0;
    pc0     = 32'h0040_0000;
    pc1     = 32'h0040_0004;
    idle();
    test_reset();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_collision();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
